// File: rtl/eq_tdm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : eq_tdm_bank
//  Purpose  : N-band graphic equaliser. A single time-multiplexed MAC runs
//             BANDS runtime-loadable FIR banks over a shared delay line.
//             Each band result is scaled by its slider gain and summed, and
//             the sum is saturated to one output sample.
//  Revision : 1.0  initial release
// ============================================================================
module eq_tdm_bank #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 15,
    parameter int BANDS  = 8,
    parameter int GAIN_W = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [DATA_W-1:0]         in_data,
    input  logic                             bypass,
    input  logic [BANDS*GAIN_W-1:0]          gain,
    input  logic                             coef_we,
    input  logic [((BANDS > 1) ? $clog2(BANDS) : 1)-1:0] coef_band,
    input  logic [((TAPS  > 1) ? $clog2(TAPS)  : 1)-1:0] coef_tap,
    input  logic signed [COEF_W-1:0]         coef_wdata,
    output logic                             coef_drop,
    output logic                             out_valid,
    output logic signed [DATA_W-1:0]         out_data
);

    localparam int BAND_W    = (BANDS > 1) ? $clog2(BANDS) : 1;
    localparam int TAP_W     = (TAPS  > 1) ? $clog2(TAPS)  : 1;
    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int ACC_W     = PROD_W + TAP_W;
    localparam int SCL_W     = DATA_W + GAIN_W + 1;
    localparam int SUM_W     = DATA_W + GAIN_W + BAND_W + 1;
    localparam int GAIN_FRAC = 4;   // gain code 16 is unity

    localparam logic [BAND_W-1:0] C_BAND_LAST = BAND_W'(BANDS - 1);
    localparam logic [TAP_W-1:0]  C_TAP_LAST  = TAP_W'(TAPS - 1);
    localparam logic signed [DATA_W-1:0] C_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] C_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_SCALE = 2'd2
    } state_t;

    state_t                     state_q;
    logic [BAND_W-1:0]          band_q;
    logic [TAP_W-1:0]           tap_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [SUM_W-1:0]    sum_q;
    logic [BANDS*GAIN_W-1:0]    gain_q;
    logic signed [DATA_W-1:0]   x_q    [TAPS];
    logic signed [COEF_W-1:0]   coef_q [BANDS][TAPS];
    logic                       out_valid_q;
    logic signed [DATA_W-1:0]   out_data_q;
    logic                       coef_drop_q;

    logic                       w_accept;
    logic                       w_coef_ok;
    logic signed [DATA_W-1:0]   w_x;
    logic signed [COEF_W-1:0]   w_h;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_acc_d;
    logic signed [ACC_W-1:0]    w_acc_sh;
    logic signed [DATA_W-1:0]   w_band;
    logic [GAIN_W-1:0]          w_gain;
    logic signed [SCL_W-1:0]    w_scl_full;
    logic signed [SCL_W-1:0]    w_scl;
    logic signed [SUM_W-1:0]    w_sum_d;
    logic signed [DATA_W-1:0]   w_out;

    // Clamp a wide signed value into DATA_W bits: in range when every bit
    // from the DATA_W-1 sign position upward agrees.
    function automatic logic signed [DATA_W-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] hi;
        hi = v[ACC_W-1:DATA_W-1];
        if ((&hi) || !(|hi)) return v[DATA_W-1:0];
        else if (v[ACC_W-1]) return C_MIN;
        else                 return C_MAX;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_sum(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-DATA_W:0] hi;
        hi = v[SUM_W-1:DATA_W-1];
        if ((&hi) || !(|hi)) return v[DATA_W-1:0];
        else if (v[SUM_W-1]) return C_MIN;
        else                 return C_MAX;
    endfunction

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign coef_drop = coef_drop_q;

    assign w_accept  = in_valid && (state_q == S_IDLE);
    // A write is only safe while the MAC is idle and no sample is being taken.
    assign w_coef_ok = coef_we && (state_q == S_IDLE) && !in_valid &&
                       (coef_band <= C_BAND_LAST) && (coef_tap <= C_TAP_LAST);

    // MAC and band scaling datapath for the current band/tap position.
    always_comb begin
        w_x        = x_q[tap_q];
        w_h        = coef_q[band_q][tap_q];
        w_prod     = w_x * w_h;
        w_acc_d    = acc_q + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        w_acc_sh   = acc_q >>> COEF_W;
        w_band     = sat_acc(w_acc_sh);
        w_gain     = gain_q[band_q*GAIN_W +: GAIN_W];
        w_scl_full = w_band * $signed({1'b0, w_gain});
        w_scl      = w_scl_full >>> GAIN_FRAC;
        w_sum_d    = sum_q + {{(SUM_W-SCL_W){w_scl[SCL_W-1]}}, w_scl};
        w_out      = sat_sum(w_sum_d);
    end

    // Frame sequencer: accept, per-band MAC/SCALE passes, output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            band_q      <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            gain_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        for (int k = TAPS-1; k > 0; k--) x_q[k] <= x_q[k-1];
                        x_q[0] <= in_data;
                        gain_q <= gain;
                        sum_q  <= '0;
                        acc_q  <= '0;
                        band_q <= '0;
                        tap_q  <= '0;
                        if (bypass) begin
                            out_data_q  <= in_data;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    acc_q <= w_acc_d;
                    if (tap_q == C_TAP_LAST) state_q <= S_SCALE;
                    else                     tap_q   <= tap_q + TAP_W'(1);
                end
                S_SCALE: begin
                    sum_q <= w_sum_d;
                    acc_q <= '0;
                    tap_q <= '0;
                    if (band_q == C_BAND_LAST) begin
                        out_data_q  <= w_out;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        band_q  <= band_q + BAND_W'(1);
                        state_q <= S_MAC;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Coefficient store with write-rejection pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_drop_q <= 1'b0;
            for (int b = 0; b < BANDS; b++)
                for (int k = 0; k < TAPS; k++)
                    coef_q[b][k] <= '0;
        end else begin
            coef_drop_q <= coef_we && !w_coef_ok;
            if (w_coef_ok) coef_q[coef_band][coef_tap] <= coef_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eq_tdm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eq_tdm_bank
//  Purpose  : Scoreboard bench for eq_tdm_bank with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eq_tdm_bank;

    localparam int LAT = 8 * (15 + 1) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               bypass;
    logic [39:0]        gain;
    logic               coef_we;
    logic [2:0]         coef_band;
    logic [3:0]         coef_tap;
    logic signed [15:0] coef_wdata;
    logic               coef_drop;
    logic               out_valid;
    logic signed [15:0] out_data;

    typedef struct {
        int data;
        int acc_edge;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   n_outs  = 0;

    eq_tdm_bank dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bypass     (bypass),
        .gain       (gain),
        .coef_we    (coef_we),
        .coef_band  (coef_band),
        .coef_tap   (coef_tap),
        .coef_wdata (coef_wdata),
        .coef_drop  (coef_drop),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Monitor: every output pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid) begin
            n_outs++;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got out_valid=1 data=%0d, required no output", out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", int'(out_data), e.data);
                check("latency", cyc + 1 - e.acc_edge, e.lat);
            end
        end
    end

    task automatic push(input int data, input int lat);
        exp_t t;
        t.data     = data;
        t.acc_edge = cyc + 1;
        t.lat      = lat;
        sb.push_back(t);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL ready_timeout: got in_ready=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic send(input int x, input int e, input int lat);
        wait_ready();
        in_valid = 1'b1;
        in_data  = 16'(x);
        push(e, lat);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wcoef(input int b, input int k, input int v, input int exp_drop);
        coef_we    = 1'b1;
        coef_band  = 3'(b);
        coef_tap   = 4'(k);
        coef_wdata = 16'(v);
        @(negedge clk);
        check("coef_drop", int'(coef_drop), exp_drop);
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending outputs, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int vals [3];
        int exps [3];
        int prev;
        int outs_before;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; bypass = 1'b0;
        gain = {8{5'd16}}; coef_we = 1'b0; coef_band = '0; coef_tap = '0;
        coef_wdata = '0;
        @(negedge clk);

        // Reset state, then all-zero coefficients give zero output.
        do_reset();
        send(1000, 0, LAT);
        drain();

        // Impulse through band 0 tap 2 (fresh delay line).
        do_reset();
        wcoef(0, 2, -32768, 0);
        send(16384, 0, LAT);
        send(0, 0, LAT);
        send(0, -8192, LAT);
        send(0, 0, LAT);
        drain();

        // Gain codes; gain changes mid-frame must not affect that frame.
        wcoef(0, 2, 0, 0);
        wcoef(0, 0, 16384, 0);
        gain = {8{5'd16}};
        send(16000, 4000, LAT);
        gain = {8{5'd31}};
        send(16000, 7750, LAT);
        gain = {8{5'd0}};
        send(16000, 0, LAT);
        drain();

        // Saturation on both rails.
        for (int b = 0; b < 8; b++) wcoef(b, 0, 32767, 0);
        gain = {8{5'd31}};
        send(32767, 32767, LAT);
        send(-32768, -32768, LAT);
        drain();

        // in_valid held high: one accept per frame; truncation on negatives.
        vals[0] = 100;  exps[0] = 752;
        vals[1] = 200;  exps[1] = 1528;
        vals[2] = -100; exps[2] = -776;
        prev = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            in_data = 16'(vals[i]);
            push(exps[i], LAT);
            if (i > 0) check("accept_interval", cyc + 1 - prev, LAT);
            prev = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Bypass: output the next cycle, ready stays high.
        bypass = 1'b1;
        send(1234, 1234, 1);
        check("bypass_ready", int'(in_ready), 1);
        bypass = 1'b0;
        drain();

        // Write during MAC is dropped; band 7 must still contribute.
        send(100, 752, LAT);
        repeat (4) @(negedge clk);
        wcoef(7, 0, 0, 1);
        drain();
        send(100, 752, LAT);
        drain();

        // Out-of-range tap index is dropped.
        wcoef(0, 15, 1000, 1);

        // Write coincident with accept: write dropped, sample accepted.
        wait_ready();
        in_valid   = 1'b1;
        in_data    = 16'sd100;
        coef_we    = 1'b1;
        coef_band  = 3'd1;
        coef_tap   = 4'd0;
        coef_wdata = 16'sd0;
        push(752, LAT);
        @(negedge clk);
        check("collide_drop", int'(coef_drop), 1);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        drain();
        send(100, 752, LAT);
        drain();

        // Reset mid-frame aborts the frame without an output.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 16'sd100;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("midframe_busy", int'(in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        outs_before = n_outs;
        repeat (150) @(negedge clk);
        check("no_out_after_rst", n_outs - outs_before, 0);

        // Reset cleared the coefficients.
        send(500, 0, LAT);
        drain();

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
